burst_buffer: RTL and testbench
===============================

# burst_buffer

Parametrised byte/word-addressable on-chip buffer with a per-lane byte-enable write port and a burst read port with valid/ready backpressure. It is the successor to the fixed 64-bit byte/word buffer. It sits between the DMA/loader and the PE-array operand fetch: writers fill it a byte or a word at a time, and the array pulls multi-word bursts at full throughput.

## Interface
- `DataW`, 64: word width in bits; multiple of 8, at least 16.
- `BuffDepth`, 256: capacity in bytes; multiple of `DataW/8`, power of two.
- `MaxBurst`, 16: maximum burst length in words; power of two.
- `Lanes`, `DataW/8`: derived; bytes per word.
- `LaneW`, `$clog2(Lanes)`: derived.
- `ByteAddrW`, `$clog2(BuffDepth)`: derived.
- `WordAddrW`, `ByteAddrW-LaneW`: derived.
- `LenW`, `$clog2(MaxBurst)`: derived.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `wr_en`  in  1  write strobe; always accepted.
- `wr_mode`  in  1  0 = byte, 1 = word.
- `wr_addr`  in  ByteAddrW  byte address. Word mode ignores the low `LaneW` bits.
- `wr_byte`  in  8  byte-mode data.
- `wr_word`  in  DataW  word-mode data.
- `wr_strb`  in  Lanes  word-mode lane enables; ignored in byte mode.
- `rd_req_valid`  in  1  burst request valid.
- `rd_req_ready`  out  1  burst request accepted when high together with valid.
- `rd_req_mode`  in  1  0 = byte (single beat), 1 = word burst.
- `rd_req_addr`  in  ByteAddrW  start byte address.
- `rd_req_len`  in  LenW  burst length minus 1; ignored in byte mode.
- `rd_valid`  out  1  response beat valid.
- `rd_ready`  in  1  consumer accepts the beat.
- `rd_word`  out  DataW  response word.
- `rd_byte`  out  8  response lane selected by the request's `addr[LaneW-1:0]`. Valid in byte mode only; 0 in word mode.
- `rd_last`  out  1  final beat of the burst.

## Operation
- **Write, byte mode:** only lane `wr_addr[LaneW-1:0]` of word `wr_addr[ByteAddrW-1:LaneW]` is written. Other lanes are untouched; there is no read-modify-write.
- **Write, word mode:** lanes with `wr_strb[i]=1` take `wr_word[8i+7:8i]`. If `wr_strb` is 0, nothing is written.
- **FSM states:** IDLE, RUN.
- **IDLE to RUN:** on request accept with word mode and `rd_req_len>0`. The first word is fetched at the accept edge. The beat counter loads `rd_req_len`.
- **IDLE after accept:** a single-beat request (byte mode, or `len=0`) stays IDLE with `rd_last=1`.
- **RUN:** each edge with `rd_valid && rd_ready` fetches the next word and decrements the counter. When the counter reaches 1, that fetch sets `rd_last=1` and the FSM returns to IDLE.
- **Stall:** while `rd_valid && !rd_ready`, all response outputs hold stable.
- **Address increment:** the word address wraps modulo `BuffDepth/Lanes`; a burst may cross the top of the buffer.
- **Request ready:** `rd_req_ready = (state==IDLE) && (!rd_valid || rd_ready)`. Back-to-back bursts therefore have no bubble.
- **Same-word collision:** when a fetch and a write hit the same word on the same edge, the fetch returns pre-write data (read-first). The exception is `BURST_BUFFER_FWD_EN`, below.
- **Reset:** reset asserted mid-burst aborts the burst. No further beats are issued, and it has no effect on memory contents.

## Timing
- **Reset values:** `rd_valid=0`, `rd_last=0`, `rd_word=0`, `rd_byte=0`, state IDLE, counter 0. Memory is not reset.
- **Reset outputs:** `rd_req_ready` is 0 during reset and 1 on the first cycle after it.
- **Write latency:** data written at edge k is readable by a fetch at edge k+1 or later.
- **Read latency:** request accepted at edge k gives `rd_valid=1` after edge k with the first word.
- **Throughput:** one beat per cycle while `rd_ready=1`. An N-word burst with continuous ready occupies N cycles.
- **Simultaneous write and request:** both happen the same cycle; the collision rule applies.

## Configuration
- **`BURST_BUFFER_FWD_EN` defined:** on a same-word collision, enabled write lanes are forwarded into `rd_word`/`rd_byte`. The response reflects post-write data.
- **`BURST_BUFFER_FWD_EN` undefined:** read-first behaviour; forwarding logic is absent.

## Structure
- **`burst_buffer_pkg`:** holds the `mode_e` enum (BYTE=0, WORD=1) and the `state_e` enum (IDLE, RUN).
- **`burst_buffer_mem` sub-module:** the `Lanes`×8-bit byte-enable synchronous array. It has one write port with lane enables and one registered read port.
- **Top level:** owns the FSM, counter, address increment, output register, lane select and forwarding.

## Test plan
- **Byte write and read:** byte write 0xA5 at addr 0x0B, then byte read at 0x0B → one beat, `rd_byte=0xA5`, `rd_last=1`. Word 1 lane 3 is 0xA5 and the other lanes are unchanged.
- **Strobed word write:** word write 0x1122334455667788 at addr 0x10 with `wr_strb=8'h0F`, over prior 0xFF.. → readback 0xFFFFFFFF55667788.
- **Burst with wrap:** burst `addr=0xF0`, `len=3`, `rd_ready=1` (DataW=64, BuffDepth=256) → words 30, 31, 0, 1 on consecutive cycles, `rd_last` on the 4th beat.
- **Backpressure and back-to-back:** `rd_ready` toggles 1,0,0,1 mid-burst → outputs stable while stalled, no beat lost or duplicated. A second request accepted on the last beat's handshake cycle has no bubble.
- **Collision:** fetch and write to the same word on the same edge → old data without `BURST_BUFFER_FWD_EN`, new data with it.
- **Reset mid-burst:** `rst` asserted at beat 2 of a len=7 burst → next cycle `rd_valid=0`, `rd_req_ready=1`, and earlier-written data is still readable.

Source files
------------

// File: rtl/burst_buffer_pkg.sv
// Shared types for the burst buffer: request/write mode and read FSM state.
package burst_buffer_pkg;

    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/burst_buffer_mem.sv
// Lane-enabled synchronous storage array with one write port and one
// registered, read-first read port.
module burst_buffer_mem
    import burst_buffer_pkg::*;
#(
    parameter int Lanes     = 8,
    parameter int WordAddrW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Lanes-1:0]       we,
    input  logic [WordAddrW-1:0]   waddr,
    input  logic [Lanes*8-1:0]     wdata,
    input  logic                   re,
    input  logic [WordAddrW-1:0]   raddr,
    output logic [Lanes*8-1:0]     rdata
);

    logic [Lanes-1:0][7:0] mem [2**WordAddrW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < Lanes; i++) begin
            if (we[i]) begin
                mem[waddr][i] <= wdata[8*i +: 8];
            end
        end
    end

    // The read register doubles as the response word, so it is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/burst_buffer.sv
// Byte/word-addressable buffer with a lane-enabled write port and a burst read
// port with valid/ready backpressure. Define BURST_BUFFER_FWD_EN for write-to-read forwarding.
module burst_buffer
    import burst_buffer_pkg::*;
#(
    parameter int DataW     = 64,
    parameter int BuffDepth = 256,
    parameter int MaxBurst  = 16,
    localparam int Lanes     = DataW / 8,
    localparam int LaneW     = $clog2(Lanes),
    localparam int ByteAddrW = $clog2(BuffDepth),
    localparam int WordAddrW = ByteAddrW - LaneW,
    localparam int LenW      = $clog2(MaxBurst)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_mode,
    input  logic [ByteAddrW-1:0] wr_addr,
    input  logic [7:0]           wr_byte,
    input  logic [DataW-1:0]     wr_word,
    input  logic [Lanes-1:0]     wr_strb,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic                 rd_req_mode,
    input  logic [ByteAddrW-1:0] rd_req_addr,
    input  logic [LenW-1:0]      rd_req_len,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DataW-1:0]     rd_word,
    output logic [7:0]           rd_byte,
    output logic                 rd_last
);

    state_e               state, state_nxt;
    logic [LenW-1:0]      cnt_p1, cnt_nxt;
    logic [WordAddrW-1:0] waddr_p1, fetch_addr;
    logic                 vld_p1, vld_nxt;
    logic                 last_p1, last_nxt;
    mode_e                mode_p1, mode_nxt;
    logic [LaneW-1:0]     lane_p1, lane_nxt;
    logic                 accept, fetch;

    logic [Lanes-1:0]     wr_we;
    logic [DataW-1:0]     wr_wdata;
    logic [WordAddrW-1:0] wr_waddr;
    logic [DataW-1:0]     mem_q;

    // Write decode: byte mode replicates the byte and enables a single lane.
    always_comb begin
        wr_we    = '0;
        wr_wdata = wr_word;
        wr_waddr = wr_addr[ByteAddrW-1:LaneW];
        if (wr_en) begin
            if (mode_e'(wr_mode) == WORD) begin
                wr_we = wr_strb;
            end else begin
                wr_we    = Lanes'(1) << wr_addr[LaneW-1:0];
                wr_wdata = {Lanes{wr_byte}};
            end
        end
    end

    assign rd_req_ready = !rst && (state == IDLE) && (!vld_p1 || rd_ready);
    assign accept       = rd_req_valid && rd_req_ready;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_p1;
        vld_nxt    = vld_p1;
        last_nxt   = last_p1;
        mode_nxt   = mode_p1;
        lane_nxt   = lane_p1;
        fetch      = 1'b0;
        fetch_addr = waddr_p1 + 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    fetch      = 1'b1;
                    fetch_addr = rd_req_addr[ByteAddrW-1:LaneW];
                    vld_nxt    = 1'b1;
                    mode_nxt   = mode_e'(rd_req_mode);
                    lane_nxt   = rd_req_addr[LaneW-1:0];
                    if (mode_e'(rd_req_mode) == WORD && rd_req_len != '0) begin
                        state_nxt = RUN;
                        cnt_nxt   = rd_req_len;
                        last_nxt  = 1'b0;
                    end else begin
                        cnt_nxt  = '0;
                        last_nxt = 1'b1;
                    end
                end else if (vld_p1 && rd_ready) begin
                    vld_nxt  = 1'b0;
                    last_nxt = 1'b0;
                end
            end
            RUN: begin
                if (vld_p1 && rd_ready) begin
                    fetch   = 1'b1;
                    cnt_nxt = cnt_p1 - 1'b1;
                    if (cnt_p1 == LenW'(1)) begin
                        last_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stage: control registers tracking the beat held in the read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt_p1   <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            mode_p1  <= BYTE;
            lane_p1  <= '0;
            waddr_p1 <= '0;
        end else begin
            state   <= state_nxt;
            cnt_p1  <= cnt_nxt;
            vld_p1  <= vld_nxt;
            last_p1 <= last_nxt;
            mode_p1 <= mode_nxt;
            lane_p1 <= lane_nxt;
            if (fetch) begin
                waddr_p1 <= fetch_addr;
            end
        end
    end

    burst_buffer_mem #(
        .Lanes     (Lanes),
        .WordAddrW (WordAddrW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_we),
        .waddr (wr_waddr),
        .wdata (wr_wdata),
        .re    (fetch),
        .raddr (fetch_addr),
        .rdata (mem_q)
    );

`ifdef BURST_BUFFER_FWD_EN
    logic [Lanes-1:0] fwd_mask_p1;
    logic [DataW-1:0] fwd_data_p1;

    // Capture lanes written to the fetched word on the fetch edge; overlay them on the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_mask_p1 <= '0;
        end else if (fetch) begin
            fwd_mask_p1 <= (wr_waddr == fetch_addr) ? wr_we : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) begin
            fwd_data_p1 <= wr_wdata;
        end
    end

    always_comb begin
        rd_word = mem_q;
        for (int i = 0; i < Lanes; i++) begin
            if (fwd_mask_p1[i]) begin
                rd_word[8*i +: 8] = fwd_data_p1[8*i +: 8];
            end
        end
    end
`else
    assign rd_word = mem_q;
`endif

    always_comb begin
        rd_byte = '0;
        if (mode_p1 == BYTE) begin
            rd_byte = rd_word[{lane_p1, 3'b000} +: 8];
        end
    end

    assign rd_valid = vld_p1;
    assign rd_last  = last_p1;

endmodule

// File: tb/tb_burst_buffer.sv
// Directed bench for burst_buffer: a byte-array/queue model checked every cycle plus literal spot checks.
module tb_burst_buffer;

    localparam int Words     = 32;
    localparam int BuffDepth = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_mode = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [7:0]  wr_byte = '0;
    logic [63:0] wr_word = '0;
    logic [7:0]  wr_strb = '0;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_mode = 1'b0;
    logic [7:0]  rd_req_addr = '0;
    logic [3:0]  rd_req_len = '0;
    logic        rd_ready = 1'b0;
    logic        rd_req_ready;
    logic        rd_valid;
    logic [63:0] rd_word;
    logic [7:0]  rd_byte;
    logic        rd_last;

    burst_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_mode      (wr_mode),
        .wr_addr      (wr_addr),
        .wr_byte      (wr_byte),
        .wr_word      (wr_word),
        .wr_strb      (wr_strb),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_mode  (rd_req_mode),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_word      (rd_word),
        .rd_byte      (rd_byte),
        .rd_last      (rd_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] word;
        logic [7:0]  bt;
        logic        last;
    } beat_t;

    int         vectors = 0;
    int         miscompares = 0;
    beat_t      q[$];
    logic [7:0] mm [BuffDepth];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Ready whenever no beat is pending beyond one being consumed this cycle.
    function automatic bit model_ready();
        return !rst && (q.size() == 0 || (q.size() == 1 && rd_ready));
    endfunction

    function automatic logic [63:0] model_word(int w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mm[(w % Words) * 8 + i];
        return r;
    endfunction

    function automatic beat_t make_beat(int w, int lane, bit byte_mode, bit last);
        beat_t b;
        b.word = model_word(w);
        b.bt   = byte_mode ? b.word[8*lane +: 8] : 8'h00;
        b.last = last;
        return b;
    endfunction

    task automatic apply_write();
        if (wr_en) begin
            if (wr_mode) begin
                for (int i = 0; i < 8; i++)
                    if (wr_strb[i]) mm[int'(wr_addr[7:3]) * 8 + i] = wr_word[8*i +: 8];
            end else begin
                mm[wr_addr] = wr_byte;
            end
        end
    endtask

    bit m_acc, m_bm;
    int m_n, m_w0, m_ln;

    // Model: on accept, queue every beat of the request from the byte array.
    initial forever begin
        @(posedge clk);
        m_acc = rd_req_valid && model_ready();
        if (rst) q.delete();
        else if (q.size() > 0 && rd_ready) void'(q.pop_front());
        if (m_acc) begin
            m_bm = (rd_req_mode == 1'b0);
            m_n  = m_bm ? 1 : rd_req_len + 1;
            m_w0 = int'(rd_req_addr[7:3]);
            m_ln = int'(rd_req_addr[2:0]);
`ifdef BURST_BUFFER_FWD_EN
            apply_write();
            q.push_back(make_beat(m_w0, m_ln, m_bm, m_n == 1));
`else
            q.push_back(make_beat(m_w0, m_ln, m_bm, m_n == 1));
            apply_write();
`endif
            for (int i = 1; i < m_n; i++) q.push_back(make_beat(m_w0 + i, m_ln, m_bm, i == m_n - 1));
        end else begin
            apply_write();
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        check("req_ready", rd_req_ready, model_ready());
        check("rd_valid", rd_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("rd_word", rd_word, q[0].word);
            check("rd_byte", rd_byte, q[0].bt);
            check("rd_last", rd_last, q[0].last);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic request(bit mode, logic [7:0] addr, logic [3:0] len);
        bit acc;
        int n = 0;
        rd_req_valid = 1'b1;
        rd_req_mode  = mode;
        rd_req_addr  = addr;
        rd_req_len   = len;
        do begin
            acc = model_ready();
            cyc();
            n++;
        end while (!acc && n < 100);
        rd_req_valid = 1'b0;
        if (!acc) timeout("req_accept");
    endtask

    task automatic drain();
        int n = 0;
        rd_ready = 1'b1;
        while (q.size() > 0 && n < 100) begin
            cyc();
            n++;
        end
        if (q.size() > 0) timeout("drain");
    endtask

    task automatic write_word(logic [7:0] addr, logic [63:0] data, logic [7:0] strb);
        wr_en = 1'b1; wr_mode = 1'b1; wr_addr = addr; wr_word = data; wr_strb = strb;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic write_byte(logic [7:0] addr, logic [7:0] data);
        wr_en = 1'b1; wr_mode = 1'b0; wr_addr = addr; wr_byte = data;
        cyc();
        wr_en = 1'b0;
    endtask

    bit pat [16] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    bit b_acc, acc;

    initial begin
        rst = 1'b1;
        cyc(); cyc();
        check("rst_valid", rd_valid, 0);
        check("rst_last", rd_last, 0);
        check("rst_word", rd_word, 0);
        check("rst_byte", rd_byte, 0);
        check("rst_req_ready", rd_req_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", rd_req_ready, 1);

        // Fill: every byte holds its own address.
        wr_en = 1'b1; wr_mode = 1'b1; wr_strb = 8'hFF;
        for (int w = 0; w < Words; w++) begin
            wr_addr = 8'(w * 8);
            for (int i = 0; i < 8; i++) wr_word[8*i +: 8] = 8'(w * 8 + i);
            cyc();
        end
        wr_en = 1'b0;

        write_byte(8'h0B, 8'hA5);
        rd_ready = 1'b1;
        request(1'b0, 8'h0B, 4'd0);
        check("byte_rd_byte", rd_byte, 8'hA5);
        check("byte_rd_last", rd_last, 1);
        check("byte_rd_word", rd_word, 64'h0F0E0D0C_A50A0908);
        drain();

        write_word(8'h10, '1, 8'hFF);
        write_word(8'h10, 64'h11223344_55667788, 8'h0F);
        request(1'b1, 8'h13, 4'd0);
        check("strb_word", rd_word, 64'hFFFFFFFF_55667788);
        check("strb_word_byte0", rd_byte, 0);
        drain();

        write_word(8'h18, 64'h01234567_89ABCDEF, 8'h00);
        request(1'b0, 8'h1B, 4'd0);
        check("zero_strb_byte", rd_byte, 8'h1B);
        drain();

        request(1'b1, 8'hF0, 4'd3);
        check("wrap_b0", rd_word, 64'hF7F6F5F4_F3F2F1F0);
        check("wrap_b0_last", rd_last, 0);
        cyc(); cyc();
        check("wrap_b2", rd_word, 64'h07060504_03020100);
        cyc();
        check("wrap_b3", rd_word, 64'h0F0E0D0C_A50A0908);
        check("wrap_b3_last", rd_last, 1);
        cyc();
        check("wrap_done", rd_valid, 0);

        request(1'b1, 8'h20, 4'd5);
        b_acc = 1'b0;
        for (int k = 0; k < 16; k++) begin
            rd_ready = pat[k];
            if (!b_acc) begin
                rd_req_valid = 1'b1; rd_req_mode = 1'b1; rd_req_addr = 8'h60; rd_req_len = 4'd2;
            end
            acc = rd_req_valid && model_ready();
            cyc();
            if (acc) begin
                b_acc = 1'b1;
                rd_req_valid = 1'b0;
                check("b2b_valid", rd_valid, 1);
                check("b2b_word", rd_word, 64'h67666564_63626160);
            end
        end
        rd_req_valid = 1'b0;
        if (!b_acc) timeout("b2b_accept");
        drain();

        rd_ready = 1'b1;
        wr_en = 1'b1; wr_mode = 1'b1; wr_addr = 8'h40; wr_word = 64'hDEADBEEF_CAFEF00D; wr_strb = 8'hFF;
        request(1'b1, 8'h40, 4'd0);
        wr_en = 1'b0;
`ifdef BURST_BUFFER_FWD_EN
        check("collide_word", rd_word, 64'hDEADBEEF_CAFEF00D);
`else
        check("collide_word", rd_word, 64'h47464544_43424140);
`endif
        drain();
        request(1'b1, 8'h40, 4'd0);
        check("after_collide", rd_word, 64'hDEADBEEF_CAFEF00D);
        drain();

        request(1'b1, 8'h80, 4'd7);
        cyc();
        rst = 1'b1;
        cyc();
        check("midrst_valid", rd_valid, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready", rd_req_ready, 1);
        request(1'b0, 8'h0B, 4'd0);
        check("midrst_byte", rd_byte, 8'hA5);
        drain();

        request(1'b1, 8'hF8, 4'd1);
        check("wrap2_b0", rd_word, 64'hFFFEFDFC_FBFAF9F8);
        drain();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

endmodule
